// File: rtl/rst_sequencer.sv
// rst_sequencer: board reset controller. Waits for a stable, synchronized PLL
// lock, then releases the reset domains one at a time, starting at bit 0.
// All domains are reasserted together on lock loss or on a software request.
// Optional feature macro: RST_SEQ_CAUSE_EN adds cause_o and rst_count_o.
module rst_sequencer #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pll_locked_i,
  input  logic                   sw_rst_i,
  output logic [NUM_DOMAINS-1:0] rst_no,
  output logic                   done_o
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [1:0]             cause_o,
  output logic [7:0]             rst_count_o
`endif
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0]          HOLD_TC = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]          STEP_TC = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0]          LAST_IX = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ND_ONE  = NUM_DOMAINS'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;

  // Lock synchronizer: the only consumer of pll_locked_i.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked_i};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next state: sequencing first, then the reassert events override it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;

    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s && !sw_rst_i) state_d = HOLD;
      end
      HOLD, RELEASE: begin
        if ((state_q == HOLD && cnt_q == HOLD_TC) ||
            (state_q == RELEASE && cnt_q == STEP_TC)) begin
          // idx_q is 0 in HOLD, so both states release bit idx_q here.
          cnt_d = '0;
          rst_d = rst_q | (ND_ONE << idx_q);
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IX) begin
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    if (!lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else if (sw_rst_i) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign rst_no = rst_q;
  assign done_o = done_q;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;
  logic [7:0] evt_cnt_q, evt_cnt_d;
  logic       sw_prev_q, sw_prev_d;
  logic       lock_evt, sw_evt;

  // Cause tracking: a held software request counts once, on its first edge.
  always_comb begin
    lock_evt  = !lock_s && (state_q != WAIT_LOCK);
    sw_evt    = lock_s && sw_rst_i && !sw_prev_q && (state_q != WAIT_LOCK);
    cause_d   = cause_q;
    evt_cnt_d = evt_cnt_q;
    sw_prev_d = sw_rst_i;
    if (lock_evt) begin
      cause_d = 2'b01;
    end else if (sw_evt) begin
      cause_d = 2'b10;
    end
    if ((lock_evt || sw_evt) && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + 8'd1;
    end
  end

  // Cause registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q   <= '0;
      evt_cnt_q <= '0;
      sw_prev_q <= 1'b0;
    end else begin
      cause_q   <= cause_d;
      evt_cnt_q <= evt_cnt_d;
      sw_prev_q <= sw_prev_d;
    end
  end

  assign cause_o     = cause_q;
  assign rst_count_o = evt_cnt_q;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed timeline followed by random lock/sw/reset
// traffic on two configurations (defaults, and 1 domain with HOLD_CYCLES=1).
module tb_rst_sequencer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned STEP = 8;

  logic       clk;
  logic       rst_ni;
  logic       pll_locked;
  logic       sw_rst;
  logic [3:0] rst_no0;
  logic       done0;
  logic [0:0] rst_no1;
  logic       done1;
`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause0, cause1;
  logic [7:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: anchor is the edge at which the hold window began (-1 = waiting).
  logic [SYNC-1:0] hist;
  int              anchor;

  rst_sequencer #(
    .NUM_DOMAINS(4),
    .HOLD_CYCLES(16),
    .STEP_CYCLES(STEP),
    .SYNC_STAGES(SYNC)
  ) u_dut0 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pll_locked_i(pll_locked),
    .sw_rst_i    (sw_rst),
    .rst_no      (rst_no0),
    .done_o      (done0)
`ifdef RST_SEQ_CAUSE_EN
    ,
    .cause_o     (cause0),
    .rst_count_o (cnt0)
`endif
  );

  rst_sequencer #(
    .NUM_DOMAINS(1),
    .HOLD_CYCLES(1),
    .STEP_CYCLES(STEP),
    .SYNC_STAGES(SYNC)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pll_locked_i(pll_locked),
    .sw_rst_i    (sw_rst),
    .rst_no      (rst_no1),
    .done_o      (done1)
`ifdef RST_SEQ_CAUSE_EN
    ,
    .cause_o     (cause1),
    .rst_count_o (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      hist   <= '0;
      anchor <= -1;
    end else begin
      hist <= {hist[SYNC-2:0], pll_locked};
      if (!hist[SYNC-1]) anchor <= -1;
      else if (sw_rst) anchor <= edge_n + 1;
      else if (anchor < 0) anchor <= edge_n + 1;
    end
  end

  function automatic int unsigned released(int anc, int n, int unsigned nd, int unsigned h);
    int unsigned r = 0;
    if (anc < 0) return 0;
    for (int unsigned k = 0; k < nd; k++) begin
      if (n >= anc + int'(h) + int'(k * STEP)) r++;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_model();
    int unsigned r0, r1;
    r0 = released(anchor, edge_n, 4, 16);
    r1 = released(anchor, edge_n, 1, 1);
    check("rst_no0", 32'(rst_no0), (32'd1 << r0) - 32'd1);
    check("done0", 32'(done0), 32'(r0 == 4));
    check("rst_no1", 32'(rst_no1), (32'd1 << r1) - 32'd1);
    check("done1", 32'(done1), 32'(r1 == 1));
  endtask

  initial begin
    int unsigned off_cnt = 0;
    int unsigned sw_cnt  = 0;
    int unsigned rst_cnt = 0;

    rst_ni     = 1'b0;
    pll_locked = 1'b0;
    sw_rst     = 1'b0;

    repeat (5) begin
      @(negedge clk);
      check_model();
      check("reset_rst_no0", 32'(rst_no0), 32'h0);
      check("reset_done0", 32'(done0), 32'h0);
    end
    rst_ni = 1'b1;

    // Directed timeline; inputs change on the negedge after edge_n.
    while (edge_n < 400) begin
      @(negedge clk);
      check_model();
      case (edge_n)
        27:  check("pu_pre0", 32'(rst_no0), 32'h0);
        28:  check("pu_rel0", 32'(rst_no0), 32'h1);
        36:  check("pu_rel1", 32'(rst_no0), 32'h3);
        44:  check("pu_rel2", 32'(rst_no0), 32'h7);
        51:  check("pu_done_pre", 32'(done0), 32'h0);
        52:  check("pu_done", 32'({done0, rst_no0}), 32'h1F);
        13:  check("nd1_rel", 32'({done1, rst_no1}), 32'h3);
        102: check("ll_pre", 32'(rst_no0), 32'hF);
        103: check("ll_assert", 32'({done0, rst_no0}), 32'h0);
        138: check("ll_relock_pre", 32'(rst_no0), 32'h0);
        139: check("ll_relock_rel0", 32'(rst_no0), 32'h1);
        201: check("sw_assert", 32'({done0, rst_no0}), 32'h0);
        218: check("sw_pre", 32'(rst_no0), 32'h0);
        219: check("sw_rel0", 32'(rst_no0), 32'h1);
        243: check("sw_done", 32'(done0), 32'h1);
        348: check("hold_loss_pre", 32'(rst_no0), 32'h0);
        349: check("hold_loss_rel0", 32'(rst_no0), 32'h1);
        357: check("mid_rel1", 32'(rst_no0), 32'h3);
        362: check("both_assert", 32'({done0, rst_no0}), 32'h0);
        default: ;
      endcase
      case (edge_n)
        9:   pll_locked = 1'b1;
        100: pll_locked = 1'b0;
        120: pll_locked = 1'b1;
        200: sw_rst = 1'b1;
        203: sw_rst = 1'b0;
        300: pll_locked = 1'b0;
        310: pll_locked = 1'b1;
        322: pll_locked = 1'b0;
        330: pll_locked = 1'b1;
        359: pll_locked = 1'b0;
        361: sw_rst = 1'b1;
        363: sw_rst = 1'b0;
        365: pll_locked = 1'b1;
        default: ;
      endcase
    end

    // Random traffic: mostly locked, occasional drops, sw pulses and resets.
    repeat (4000) begin
      @(negedge clk);
      check_model();

      if (off_cnt > 0) begin
        off_cnt--;
        pll_locked = 1'b0;
      end else if ($urandom_range(0, 99) < 2) begin
        off_cnt    = $urandom_range(0, 25);
        pll_locked = 1'b0;
      end else begin
        pll_locked = 1'b1;
      end

      if (sw_cnt > 0) begin
        sw_cnt--;
        sw_rst = 1'b1;
      end else if ($urandom_range(0, 99) < 1) begin
        sw_cnt = $urandom_range(0, 5);
        sw_rst = 1'b1;
      end else begin
        sw_rst = 1'b0;
      end

      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_ni = 1'b1;
      end else if ($urandom_range(0, 999) < 3) begin
        rst_cnt = $urandom_range(1, 3);
        rst_ni  = 1'b0;
        #1;
        check("async_rst_no0", 32'(rst_no0), 32'h0);
        check("async_done0", 32'(done0), 32'h0);
        check("async_rst_no1", 32'(rst_no1), 32'h0);
        check_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
